div_sched: RTL and testbench
============================

# div_sched

Runtime configuration controller for the shared clock divider. Up to NUM_REQ clients (motor PWM, sensor trigger, telemetry timebase) request a new half-period. The block arbitrates round-robin and loads the winner's value only at a full-period boundary, so Clk_Out never glitches or produces a runt phase. It also emits a one-cycle Tick on every Clk_Out rising edge for logic clocked by Clk_In.

## Interface

- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 16: half-period and counter width.
- DEFAULT_HALF, 1: half-period (in Clk_In cycles) loaded at reset.

- Clk_In  input  1  system clock; all logic on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  NUM_REQ  level request per client; held until that client's Grant bit pulses.
- Half_Period  input  NUM_REQ*WIDTH  requested half-period; client i uses bits [i*WIDTH +: WIDTH]; must be stable while Req[i] is high.
- Grant  output  NUM_REQ  one-hot, one-cycle pulse; the granted value is in effect.
- Busy  output  1  high while a latched request waits for a boundary.
- Active_Id  output  clog2(NUM_REQ)  index of the last granted client.
- Clk_Out  output  1  divided clock, registered.
- Tick  output  1  one-cycle pulse coinciding with each Clk_Out 0→1 transition.

## Operation

- Divider: counter cnt (WIDTH bits) and active half-period H.
  - If cnt == H-1: cnt←0 and Clk_Out toggles; otherwise cnt←cnt+1.
  - Output period is 2·H Clk_In cycles.
  - A Half_Period of 0 is loaded as 1; no other clamping.
- Boundary cycle: cnt == H-1 and Clk_Out == 1, i.e. the edge at which Clk_Out falls.
- FSM states: IDLE, PEND.
  - IDLE:
    - If any unmasked Req bit is high, pick the first set bit searching from ptr+1 upward with wrap.
    - Latch its index and Half_Period slice, then go to PEND.
    - Mask: the Req bit of a client whose Grant is high in the current cycle is ignored.
  - PEND, boundary cycle: at the clock edge, H←latched value (0→1), cnt←0, Clk_Out←0, ptr←index, Active_Id←index, Grant[index]←1 for one cycle; go to IDLE.
  - PEND, non-boundary cycle: divider runs normally; stay in PEND.
  - A client dropping Req while in PEND does not cancel; the latched value is still applied and granted.
- Rate limit: at most one reconfiguration per output period.
- Tick←1 exactly when Clk_Out transitions 0→1, else 0.
- Reset value of ptr is NUM_REQ-1, so client 0 wins the first arbitration.

## Timing

- Reset values (asynchronous, while Reset_n = 0): cnt=0, H=DEFAULT_HALF, Clk_Out=0, Tick=0, Grant=0, Busy=0, Active_Id=0, ptr=NUM_REQ-1, FSM=IDLE.
- Reset assertion mid-PEND discards the pending request and no Grant is issued. The client must re-request after Reset_n rises.
- Request latency: Req high at edge t (FSM in IDLE) → Busy=1 from t+1.
- Grant and the new H appear after the first boundary edge b, with b > t.
- Worst-case Req-to-Grant for a single client: 1 + 2·H_old cycles.
- Busy falls in the same cycle Grant rises. Busy and Grant are never both high.
- After Grant, the first Clk_Out low phase lasts H_new cycles, then high for H_new cycles.
- Simultaneous requests: served one per boundary in round-robin order from ptr+1.
- A request arriving in PEND waits. A request arriving in the Grant cycle is arbitrated in the next IDLE cycle.
- Clients must deassert Req in the cycle their Grant is high. A Req still high one cycle later counts as a new request.

## Test plan

- Reset: Reset_n=0 mid-PEND with DEFAULT_HALF=1 → all outputs 0, no Grant. After release, Clk_Out toggles every cycle (period 2) and Tick pulses every 2 cycles.
- Single request: Req[0]=1, Half_Period[0]=3 → Busy next cycle, Grant[0] on the first falling boundary. Then Clk_Out low 3 and high 3 cycles, Active_Id=0.
- Round-robin: Req=4'b1011 held, values 2/4/_/5 → grants in order 0,1,3,0. Exactly one Grant per output period, each aligned with a Clk_Out fall.
- Zero value: Req[2]=1, Half_Period[2]=0 → Grant[2], then Clk_Out period 2 cycles, with no stall and no counter wrap.
- Withdrawn request: Req[1] pulsed for 1 cycle, value 6 → still granted at the boundary. Subsequent period is 12 cycles.
- Glitch check: random requests and values 1..20 for 10k cycles → every Clk_Out high and low phase length equals the H in effect. Tick count equals the number of Clk_Out rises.

Source files
------------

// File: rtl/div_sched.sv
// Shared clock divider with round-robin runtime reload of the half-period; Clk_Out and Tick are registered.
// Latency: Grant lands on the first Clk_Out fall after a request is latched; backpressure: Req is held (Busy) until its Grant.
module div_sched #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 16,
    parameter int DEFAULT_HALF = 1,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     Clk_In,
    input  logic                     Reset_n,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] Half_Period,
    output logic [NUM_REQ-1:0]       Grant,
    output logic                     Busy,
    output logic [IDW-1:0]           Active_Id,
    output logic                     Clk_Out,
    output logic                     Tick
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_HALF);

    state_t                          state;
    logic [WIDTH-1:0]                cnt;
    logic [WIDTH-1:0]                half;
    logic [WIDTH-1:0]                lat_val;
    logic [IDW-1:0]                  ptr;
    logic [IDW-1:0]                  lat_idx;
    logic [IDW-1:0]                  pick;
    logic [IDW-1:0]                  cand;
    logic                            pick_vld;
    logic                            wrap;
    logic                            boundary;
    logic [NUM_REQ-1:0]              req_masked;
    logic [NUM_REQ-1:0][WIDTH-1:0]   hp;

    assign hp         = Half_Period;
    assign req_masked = Req & ~Grant;
    assign wrap       = (cnt == half - ONE);
    // Reloading only as Clk_Out falls keeps every phase a full half-period.
    assign boundary   = wrap && Clk_Out;

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!pick_vld && req_masked[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            half      <= DEF_H;
            Clk_Out   <= 1'b0;
            Tick      <= 1'b0;
            Grant     <= '0;
            Busy      <= 1'b0;
            Active_Id <= '0;
            ptr       <= IDW'(NUM_REQ - 1);
            lat_idx   <= '0;
            lat_val   <= '0;
        end else begin
            Grant <= '0;
            Tick  <= 1'b0;
            if (state == PEND && boundary) begin
                half      <= (lat_val == '0) ? ONE : lat_val;
                cnt       <= '0;
                Clk_Out   <= 1'b0;
                ptr       <= lat_idx;
                Active_Id <= lat_idx;
                Grant     <= NUM_REQ'(1) << lat_idx;
                Busy      <= 1'b0;
                state     <= IDLE;
            end else begin
                if (wrap) begin
                    cnt     <= '0;
                    Clk_Out <= ~Clk_Out;
                    Tick    <= ~Clk_Out;
                end else begin
                    cnt <= cnt + ONE;
                end
                if (state == IDLE && pick_vld) begin
                    lat_idx <= pick;
                    lat_val <= hp[pick];
                    Busy    <= 1'b1;
                    state   <= PEND;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: phase-level reference model checked every cycle plus directed literal scenarios.
module tb_div_sched;

    localparam int NR = 4;
    localparam int W  = 16;

    logic            Clk_In = 1'b0;
    logic            Reset_n = 1'b1;
    logic [NR-1:0]   Req = '0;
    logic [NR*W-1:0] Half_Period = '0;
    logic [NR-1:0]   Grant;
    logic            Busy;
    logic [1:0]      Active_Id;
    logic            Clk_Out;
    logic            Tick;

    div_sched #(.NUM_REQ(NR), .WIDTH(W), .DEFAULT_HALF(1)) dut (
        .Clk_In(Clk_In), .Reset_n(Reset_n), .Req(Req), .Half_Period(Half_Period),
        .Grant(Grant), .Busy(Busy), .Active_Id(Active_Id), .Clk_Out(Clk_Out), .Tick(Tick)
    );

    always #5 Clk_In = ~Clk_In;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: output level, cycles spent in the current phase, half-period in effect,
    // and at most one pending (client, value) request.
    int m_lvl, m_el, m_h, m_pend, m_ptr, m_act, m_id, m_val, m_tick;
    int was_pend, ptr_prev, c;
    logic [NR-1:0] m_grant, g_prev;

    always @(posedge Clk_In or negedge Reset_n) begin
        if (!Reset_n) begin
            m_lvl = 0; m_el = 0; m_h = 1; m_pend = 0; m_ptr = NR - 1;
            m_act = 0; m_id = 0; m_val = 0; m_tick = 0; m_grant = '0;
        end else begin
            g_prev   = m_grant;
            was_pend = m_pend;
            ptr_prev = m_ptr;
            m_grant  = '0;
            m_tick   = 0;
            if (m_pend == 1 && m_el + 1 == m_h && m_lvl == 1) begin
                m_h   = (m_val == 0) ? 1 : m_val;
                m_lvl = 0; m_el = 0;
                m_ptr = m_id; m_act = m_id;
                m_grant[m_id] = 1'b1;
                m_pend = 0;
            end else if (m_el + 1 == m_h) begin
                m_lvl  = 1 - m_lvl;
                m_el   = 0;
                m_tick = m_lvl;
            end else begin
                m_el++;
            end
            if (was_pend == 0) begin
                for (int k = 1; k <= NR; k++) begin
                    c = (ptr_prev + k) % NR;
                    if (m_pend == 0 && Req[c] && !g_prev[c]) begin
                        m_pend = 1;
                        m_id   = c;
                        m_val  = int'(Half_Period[c*W +: W]);
                    end
                end
            end
        end
    end

    bit   chk_en = 0;
    bit   glitch_on = 0;
    bit   run_valid = 0;
    logic prev_clk = 1'b0;
    int   run_n = 0, run_h = 0, rises = 0, ticks = 0;

    always @(negedge Clk_In) begin
        if (chk_en) begin
            check("Clk_Out", int'(Clk_Out), m_lvl);
            check("Tick", int'(Tick), m_tick);
            check("Grant", int'(Grant), int'(m_grant));
            check("Busy", int'(Busy), m_pend);
            check("Active_Id", int'(Active_Id), m_act);
            if (glitch_on) begin
                if (Clk_Out == prev_clk) begin
                    run_n++;
                end else begin
                    if (run_valid) check("phase_len", run_n, run_h);
                    if (Clk_Out) rises++;
                    run_n = 1;
                    run_h = m_h;
                    run_valid = 1;
                end
                if (Tick) ticks++;
            end
        end
        prev_clk = Clk_Out;
    end

    task automatic wait_grant(output int id, output int lat, output bit fall_ok);
        logic prev;
        prev = Clk_Out;
        lat = 0; id = -1; fall_ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk_In);
            lat++;
            if (Grant != '0) begin
                for (int j = 0; j < NR; j++) if (Grant[j]) id = j;
                fall_ok = prev && !Clk_Out;
                return;
            end
            prev = Clk_Out;
        end
        check("grant_timeout", 0, 1);
    endtask

    task automatic run_len(output int n);
        logic lv;
        lv = Clk_Out;
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk_In);
            if (Clk_Out !== lv) return;
            n++;
        end
    endtask

    task automatic check_released();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk_In);
            check("rel_clk", int'(Clk_Out), (i % 2 == 0) ? 1 : 0);
            check("rel_tick", int'(Tick), (i % 2 == 0) ? 1 : 0);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk_In);
        #2 Reset_n = 1'b0;
        Req = '0;
        repeat (2) @(negedge Clk_In);
        #2 Reset_n = 1'b1;
    endtask

    int id, lat, n_lo, n_hi, gcount;
    bit fall;
    int rr_exp_id[4]  = '{0, 1, 3, 0};
    int rr_exp_gap[4] = '{0, 4, 8, 10};

    initial begin
        #1 Reset_n = 1'b0;
        repeat (3) @(negedge Clk_In);
        chk_en = 1;
        @(negedge Clk_In);
        check("rst_clk", int'(Clk_Out), 0);
        check("rst_grant", int'(Grant), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_id", int'(Active_Id), 0);
        #2 Reset_n = 1'b1;
        check_released();

        // Single request, value 3
        @(negedge Clk_In);
        Half_Period[0*W +: W] = 16'd3;
        Req[0] = 1'b1;
        @(negedge Clk_In);
        check("single_busy", int'(Busy), 1);
        wait_grant(id, lat, fall);
        Req[0] = 1'b0;
        check("single_id", id, 0);
        check("single_latency_le_2", int'(lat >= 1 && lat <= 2), 1);
        check("single_busy_at_grant", int'(Busy), 0);
        check("single_active", int'(Active_Id), 0);
        run_len(n_lo);
        run_len(n_hi);
        check("single_low", n_lo, 3);
        check("single_high", n_hi, 3);

        // Round-robin from a fresh pointer: 0,1,3,0 with gaps 2*H_prev
        do_reset();
        Half_Period[0*W +: W] = 16'd2;
        Half_Period[1*W +: W] = 16'd4;
        Half_Period[3*W +: W] = 16'd5;
        Req = 4'b1011;
        for (int g = 0; g < 4; g++) begin
            wait_grant(id, lat, fall);
            if (g == 3) Req = '0;
            check("rr_order", id, rr_exp_id[g]);
            check("rr_at_fall", int'(fall), 1);
            if (g > 0) check("rr_gap", lat, rr_exp_gap[g]);
        end

        // Zero half-period loads as 1
        Half_Period[2*W +: W] = 16'd0;
        Req[2] = 1'b1;
        wait_grant(id, lat, fall);
        Req[2] = 1'b0;
        check("zero_id", id, 2);
        check("zero_active", int'(Active_Id), 2);
        run_len(n_lo);
        run_len(n_hi);
        check("zero_low", n_lo, 1);
        check("zero_high", n_hi, 1);

        // One-cycle request pulse is still honoured
        @(negedge Clk_In);
        Half_Period[1*W +: W] = 16'd6;
        Req[1] = 1'b1;
        @(negedge Clk_In);
        Req[1] = 1'b0;
        wait_grant(id, lat, fall);
        check("wd_id", id, 1);
        run_len(n_lo);
        run_len(n_hi);
        check("wd_period", n_lo + n_hi, 12);

        // Reset while a request is pending: nothing granted afterwards
        Half_Period[0*W +: W] = 16'd10;
        Req[0] = 1'b1;
        @(negedge Clk_In);
        check("mid_busy", int'(Busy), 1);
        #2 Reset_n = 1'b0;
        Req = '0;
        @(negedge Clk_In);
        check("mid_rst_busy", int'(Busy), 0);
        check("mid_rst_grant", int'(Grant), 0);
        check("mid_rst_clk", int'(Clk_Out), 0);
        check("mid_rst_tick", int'(Tick), 0);
        #2 Reset_n = 1'b1;
        check_released();
        gcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk_In);
            if (Grant != '0) gcount++;
        end
        check("mid_no_grant", gcount, 0);

        // Random load: requests held until granted, values 1..20
        @(negedge Clk_In);
        run_valid = 0;
        glitch_on = 1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge Clk_In);
            for (int i = 0; i < NR; i++) begin
                if (Req[i] && Grant[i]) begin
                    Req[i] = 1'b0;
                end else if (!Req[i] && $urandom_range(0, 15) == 0) begin
                    Half_Period[i*W +: W] = W'($urandom_range(1, 20));
                    Req[i] = 1'b1;
                end
            end
        end
        glitch_on = 0;
        Req = '0;
        check("tick_vs_rises", ticks, rises);

        repeat (2) @(negedge Clk_In);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
